// File: rtl/axi4l_gpio_pkg.sv
// Shared definitions for the multi-channel AXI4-lite GPIO block:
// register offsets within a channel window, channel stride, AXI response
// codes, the decoded-address record, and the helpers for address decode
// and write-strobe expansion.
package axi4l_gpio_pkg;

  localparam logic [4:0]  OFF_OUT      = 5'h00;
  localparam logic [4:0]  OFF_DIR      = 5'h04;
  localparam logic [4:0]  OFF_IN       = 5'h08;
  localparam logic [4:0]  OFF_IRQ_EN   = 5'h0C;
  localparam logic [4:0]  OFF_IRQ_STAT = 5'h10;
  localparam logic [31:0] CH_STRIDE    = 32'h20;
  localparam int          CH_SHIFT     = $clog2(CH_STRIDE);

  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [1:0]  RESP_SLVERR  = 2'b10;

  typedef enum logic [2:0] {
    REG_NONE, REG_OUT, REG_DIR, REG_IN, REG_IRQ_EN, REG_IRQ_STAT
  } reg_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] ch;
    reg_e       rsel;
  } dec_t;

  // Decode a byte address into {valid, channel, register}. The low two
  // address bits are ignored; anything outside a populated channel or on
  // an unused offset comes back invalid with rsel = REG_NONE.
  function automatic dec_t addr_decode(input logic [31:0] addr,
                                       input logic [31:0] num_ch);
    dec_t        d;
    logic [31:0] ch_idx;
    ch_idx = addr >> CH_SHIFT;
    d.ch   = ch_idx[2:0];
    case ({addr[4:2], 2'b00})
      OFF_OUT:      d.rsel = REG_OUT;
      OFF_DIR:      d.rsel = REG_DIR;
      OFF_IN:       d.rsel = REG_IN;
      OFF_IRQ_EN:   d.rsel = REG_IRQ_EN;
      OFF_IRQ_STAT: d.rsel = REG_IRQ_STAT;
      default:      d.rsel = REG_NONE;
    endcase
    d.valid = (ch_idx < num_ch) && (d.rsel != REG_NONE);
    if (!d.valid) d.rsel = REG_NONE;
    return d;
  endfunction

  // Byte enables -> bit mask.
  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
    return m;
  endfunction

endpackage

// File: rtl/gpio_channel.sv
// One GPIO channel: OUT / DIR / IRQ_EN registers, input synchroniser with
// a history flop for rising-edge detect, and the W1C interrupt status.
// Ports: clk/resetn; wr_en/wr_reg/wdata/wmask (one masked register write
// per cycle); rd_reg -> rd_data (combinational, zero-extended to 32);
// gpio_in (async pads), gpio_out, gpio_oe; stat_any = OR of IRQ_STAT.
module gpio_channel
  import axi4l_gpio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en,
  input  reg_e             wr_reg,
  input  logic [31:0]      wdata,
  input  logic [31:0]      wmask,
  input  reg_e             rd_reg,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic [31:0]      rd_data,
  output logic             stat_any
);

  logic [WIDTH-1:0] out_q, out_d, dir_q, dir_d, en_q, en_d;
  logic [WIDTH-1:0] stat_q, stat_d, hist_q, hist_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] wd, wm, clr, rise, in_s;

  assign wd   = wdata[WIDTH-1:0];
  assign wm   = wmask[WIDTH-1:0];
  assign in_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    en_d   = en_q;
    clr    = '0;
    if (wr_en) begin
      case (wr_reg)
        REG_OUT:      out_d = (out_q & ~wm) | (wd & wm);
        REG_DIR:      dir_d = (dir_q & ~wm) | (wd & wm);
        REG_IRQ_EN:   en_d  = (en_q  & ~wm) | (wd & wm);
        REG_IRQ_STAT: clr   = wd & wm;
        default:      ;
      endcase
    end
    sync_d = {sync_q[SYNC_STAGES-2:0], gpio_in};
    hist_d = in_s;
    rise   = in_s & ~hist_q & en_q;
    // Set is OR'd in after the clear so a same-cycle edge is never lost.
    stat_d = (stat_q & ~clr) | rise;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_q  <= '0;
      dir_q  <= '0;
      en_q   <= '0;
      stat_q <= '0;
      hist_q <= '0;
      sync_q <= '0;
    end else begin
      out_q  <= out_d;
      dir_q  <= dir_d;
      en_q   <= en_d;
      stat_q <= stat_d;
      hist_q <= hist_d;
      sync_q <= sync_d;
    end
  end

  always_comb begin
    rd_data = 32'h0;
    case (rd_reg)
      REG_OUT:      rd_data = 32'(out_q);
      REG_DIR:      rd_data = 32'(dir_q);
      REG_IN:       rd_data = 32'(in_s);
      REG_IRQ_EN:   rd_data = 32'(en_q);
      REG_IRQ_STAT: rd_data = 32'(stat_q);
      default:      rd_data = 32'h0;
    endcase
  end

  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;
  assign stat_any = |stat_q;

endmodule

// File: rtl/axi4l_gpio_multi.sv
// AXI4-lite GPIO slave with NUM_CH channels of WIDTH bits. Owns the AW/W
// latches and B response, the AR/R response register and the read mux;
// per-channel state lives in gpio_channel instances.
// Ports: clk/resetn (sync, active-low); AXI4-lite slave s_*; gpio_in
// (async pads), gpio_out, gpio_oe (1 = drive); irq (level, registered).
module axi4l_gpio_multi
  import axi4l_gpio_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int WIDTH       = 32,
  parameter int ADDR_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [ADDR_W-1:0]       s_awaddr,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [31:0]             s_wdata,
  input  logic [3:0]              s_wstrb,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  input  logic [ADDR_W-1:0]       s_araddr,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  output logic [31:0]             s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  input  logic [NUM_CH*WIDTH-1:0] gpio_in,
  output logic [NUM_CH*WIDTH-1:0] gpio_out,
  output logic [NUM_CH*WIDTH-1:0] gpio_oe,
  output logic                    irq
);

  logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              bvalid_q, bvalid_d, rvalid_q, rvalid_d, irq_q, irq_d;
  logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              aw_hs, w_hs, ar_hs, do_wr;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data, rd_sel;
  logic [3:0]        wr_strb;
  dec_t              wdec, rdec;
  logic [NUM_CH-1:0][31:0] ch_rd;
  logic [NUM_CH-1:0] ch_stat, ch_wr;

  // Readies are gated by resetn so nothing is accepted while in reset.
  assign s_awready = resetn & ~aw_held_q & ~bvalid_q;
  assign s_wready  = resetn & ~w_held_q  & ~bvalid_q;
  assign s_arready = resetn & ~rvalid_q;

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid  & s_wready;
  assign ar_hs = s_arvalid & s_arready;

  // A handshake this cycle counts as held, so simultaneous AW+W commits
  // at the very next edge.
  assign do_wr   = (aw_held_q | aw_hs) & (w_held_q | w_hs);
  assign wr_addr = aw_held_q ? awaddr_q : s_awaddr;
  assign wr_data = w_held_q  ? wdata_q  : s_wdata;
  assign wr_strb = w_held_q  ? wstrb_q  : s_wstrb;
  assign wdec    = addr_decode(32'(wr_addr),  32'(NUM_CH));
  assign rdec    = addr_decode(32'(s_araddr), 32'(NUM_CH));

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign ch_wr[c] = do_wr & wdec.valid & (wdec.ch == 3'(c));
    gpio_channel #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_ch (
      .clk      (clk),
      .resetn   (resetn),
      .wr_en    (ch_wr[c]),
      .wr_reg   (wdec.rsel),
      .wdata    (wr_data),
      .wmask    (strb_mask(wr_strb)),
      .rd_reg   (rdec.rsel),
      .gpio_in  (gpio_in[c*WIDTH +: WIDTH]),
      .gpio_out (gpio_out[c*WIDTH +: WIDTH]),
      .gpio_oe  (gpio_oe[c*WIDTH +: WIDTH]),
      .rd_data  (ch_rd[c]),
      .stat_any (ch_stat[c])
    );
  end

  always_comb begin
    rd_sel = 32'h0;
    for (int c = 0; c < NUM_CH; c++)
      if (rdec.valid && rdec.ch == 3'(c)) rd_sel = ch_rd[c];
  end

  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = s_awaddr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_wdata;
      wstrb_d  = s_wstrb;
    end
    if (do_wr) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wdec.valid ? RESP_OKAY : RESP_SLVERR;
    end else if (bvalid_q && s_bready) begin
      bvalid_d = 1'b0;
    end
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_sel;
      rresp_d  = rdec.valid ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && s_rready) begin
      rvalid_d = 1'b0;
    end
    irq_d = |ch_stat;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      irq_q     <= irq_d;
    end
  end

  assign s_bvalid = bvalid_q;
  assign s_bresp  = bresp_q;
  assign s_rvalid = rvalid_q;
  assign s_rdata  = rdata_q;
  assign s_rresp  = rresp_q;
  assign irq      = irq_q;

endmodule

// File: doc/axi4l_gpio_multi.md
Name: axi4l_gpio_multi

Overview:
- Parametrised AXI4-lite GPIO slave with NUM_CH independent channels of WIDTH bits each.
- Each channel has an output register, a per-bit direction register, a synchronised input path and per-bit rising-edge interrupts.
- Sits on the Zynq PS general-purpose AXI port. Replaces the single 32-bit GPIO register block.

Parameters:
- NUM_CH, 2, number of GPIO channels (1..8).
- WIDTH, 32, bits per channel (1..32).
- ADDR_W, 12, AXI address width.
- SYNC_STAGES, 2, input synchroniser flops (2..3).

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- s_awaddr  in  ADDR_W  write address
- s_awvalid / s_awready  in / out  1  AW handshake
- s_wdata  in  32  write data
- s_wstrb  in  4  byte enables
- s_wvalid / s_wready  in / out  1  W handshake
- s_bresp  out  2  write response
- s_bvalid / s_bready  out / in  1  B handshake
- s_araddr  in  ADDR_W  read address
- s_arvalid / s_arready  in / out  1  AR handshake
- s_rdata  out  32  read data
- s_rresp  out  2  read response
- s_rvalid / s_rready  out / in  1  R handshake
- gpio_in  in  NUM_CH*WIDTH  pad inputs, asynchronous
- gpio_out  out  NUM_CH*WIDTH  output values
- gpio_oe  out  NUM_CH*WIDTH  output enables (1 = drive)
- irq  out  1  level interrupt

Behaviour:

Register map:
- Channel c base = c*0x20. Word-aligned; awaddr/araddr[1:0] ignored.
- +0x00 OUT (RW)
- +0x04 DIR (RW, 1 = output)
- +0x08 IN (RO, synchronised)
- +0x0C IRQ_EN (RW)
- +0x10 IRQ_STAT (W1C)
- Bits above WIDTH read 0 and ignore writes.
- Unmapped offset, or c >= NUM_CH: writes have no effect and return SLVERR (2'b10); reads return 0 with SLVERR. Mapped accesses return OKAY (2'b00).

Reset values:
- All registers 0, so gpio_out = 0 and gpio_oe = 0.
- s_awready, s_wready, s_arready, s_bvalid, s_rvalid, irq = 0.
- bresp, rresp, rdata = 0.
- Synchroniser and edge-history flops = 0.

Write channel:
- AW and W are accepted independently. awready is high while no address is latched and bvalid = 0; wready is high while no data is latched and bvalid = 0. Either may arrive first and is held.
- The cycle both are held: the register is updated with byte-lane masking by wstrb, bvalid is set the next cycle, and both latches clear.
- bvalid holds until bready. No new AW or W is accepted while bvalid = 1.
- Simultaneous AW+W in cycle N gives the register update at edge N+1 and bvalid high in cycle N+1.

Read channel:
- arready = 1 whenever rvalid = 0 and not in reset.
- Handshake in cycle N gives rdata/rresp registered and rvalid high in cycle N+1.
- rvalid, rdata and rresp hold stable until rready.

Read/write ordering:
- A read of a register being written in the same cycle returns the old value.

Input path:
- gpio_in passes through SYNC_STAGES flops, then a 1-cycle history flop.
- IN reads the final synchroniser stage.
- A pad change is visible in IN after SYNC_STAGES cycles.

Interrupts:
- rise[i] = sync[i] & ~hist[i] & IRQ_EN[i] sets IRQ_STAT[i].
- A W1C write clears the bits written as 1 (after wstrb masking).
- Same-cycle set and clear on one bit: set wins.
- irq = registered OR over all channels of IRQ_STAT, so it lags the status bit by 1 cycle.
- Edges are detected regardless of DIR.

Reset mid-operation:
- Pending latched AW/W, bvalid and rvalid are dropped immediately.
- No response is issued for a transaction that was in flight.

Decomposition:
- Package axi4l_gpio_pkg: register offset constants (OFF_OUT, OFF_DIR, OFF_IN, OFF_IRQ_EN, OFF_IRQ_STAT), CH_STRIDE = 0x20, RESP_OKAY / RESP_SLVERR, and an address-decode function returning {valid, ch, reg}.
- One sub-module, gpio_channel: holds one channel's registers, synchroniser, edge detect and W1C logic. It is instantiated NUM_CH times via generate.
- The top level owns the AXI handshake FSMs and the read mux.

Test Plan:
- Reset, then write 0xA5A5_A5A5 to 0x000 with AW and W in the same cycle -> bvalid high in the next cycle, bresp = 0, gpio_out[31:0] = 0xA5A5_A5A5.
- W presented 3 cycles before AW to 0x024 (ch1 DIR) with wstrb = 4'b0011 and data 0xFFFF_FFFF -> gpio_oe[63:32] = 0x0000_FFFF. bready held low 4 cycles -> bvalid stays high, and no awready/wready during that time.
- Drive gpio_in[0] 0 -> 1 with IRQ_EN0 = 0x1 -> IN0 reads 1 after 2 cycles, IRQ_STAT0 = 0x1, irq high. Write 0x1 to 0x010 -> irq low. Repeat with a rising edge in the same cycle as the W1C write -> the bit stays set.
- Read 0x040 (ch2 with NUM_CH = 2) and write 0x014 (unmapped) -> rresp = bresp = 2'b10, rdata = 0, no register changes.
- Read with rready low 5 cycles -> rvalid and rdata stable, arready low. A second AR is accepted only after the R handshake.
- Assert resetn = 0 while bvalid = 1 and a read is pending -> next cycle all valids and readies are 0 and gpio_out = 0.
